// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding and PS/2 device response/command bytes
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_TX, WAIT_ACK} state_t;
  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_ERROR    = 8'hFC;
  localparam logic [7:0] PS2_SET_LEDS = 8'hED;
  function automatic logic is_response(input logic [7:0] b);
    return b == PS2_ACK || b == PS2_RESEND || b == PS2_ERROR;
  endfunction
endpackage

// File: rtl/ps2_ack_timer.sv
// ps2_ack_timer: saturating response-wait counter with clear/enable and expired flag
module ps2_ack_timer #(
  parameter int ACK_TIMEOUT = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(ACK_TIMEOUT - 1);
  logic [W-1:0] count;
  assign expired = count == LAST;
  // count up while enabled, holding at the last value so it never wraps
  always_ff @(posedge clk)
    count <= (reset || clear) ? '0 : (enable && !expired) ? count + 1'b1 : count;
endmodule

// File: rtl/ps2_cmd_sequencer.sv
// ps2_cmd_sequencer: sends opcode (+ optional argument) to a PS/2 device, awaits ACK per byte; optional resend via PS2_CMD_RETRY_EN
module ps2_cmd_sequencer
  import ps2_pkg::*;
#(
  parameter int ACK_TIMEOUT = 2_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] arg_byte,
  output logic       w_enable,
  output logic [7:0] data,
  input  logic       tx_finished,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_byte,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       cmd_done,
  output logic       cmd_err,
  output logic       busy
);
  state_t     state;
  logic [7:0] cmd_q, arg_q;
  logic       has_arg_q, phase, expired, fwd;
`ifdef PS2_CMD_RETRY_EN
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retries;
`endif
  assign cmd_ready = state == IDLE;
  assign busy      = ~cmd_ready;
  assign fwd       = rx_done_tick && (state != WAIT_ACK || !is_response(rx_byte));
  ps2_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
    .clk(clk),
    .reset(reset),
    .clear(state == WAIT_TX && tx_finished),
    .enable(state == WAIT_ACK),
    .expired(expired)
  );
  // command FSM; w_enable/data are set on entry to LOAD so the strobe spans exactly the LOAD cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      w_enable   <= 1'b0;
      data       <= '0;
      scan_valid <= 1'b0;
      scan_code  <= '0;
      cmd_done   <= 1'b0;
      cmd_err    <= 1'b0;
      cmd_q      <= '0;
      arg_q      <= '0;
      has_arg_q  <= 1'b0;
      phase      <= 1'b0;
`ifdef PS2_CMD_RETRY_EN
      retries    <= '0;
`endif
    end else begin
      w_enable   <= 1'b0;
      cmd_done   <= 1'b0;
      cmd_err    <= 1'b0;
      scan_valid <= fwd;
      if (fwd) scan_code <= rx_byte;
      case (state)
        IDLE: if (cmd_valid) begin
          cmd_q     <= cmd_byte;
          arg_q     <= arg_byte;
          has_arg_q <= cmd_has_arg;
          phase     <= 1'b0;
`ifdef PS2_CMD_RETRY_EN
          retries   <= '0;
`endif
          data      <= cmd_byte;
          w_enable  <= 1'b1;
          state     <= LOAD;
        end
        LOAD: state <= WAIT_TX;
        WAIT_TX: if (tx_finished) state <= WAIT_ACK;
        WAIT_ACK: begin
          if (rx_done_tick && rx_byte == PS2_ACK) begin
            if (!phase && has_arg_q) begin
              phase    <= 1'b1;
`ifdef PS2_CMD_RETRY_EN
              retries  <= '0;
`endif
              data     <= arg_q;
              w_enable <= 1'b1;
              state    <= LOAD;
            end else begin
              cmd_done <= 1'b1;
              state    <= IDLE;
            end
          end else if (rx_done_tick && rx_byte == PS2_RESEND) begin
`ifdef PS2_CMD_RETRY_EN
            if (retries < RW'(MAX_RETRY)) begin
              retries  <= retries + 1'b1;
              data     <= phase ? arg_q : cmd_q;
              w_enable <= 1'b1;
              state    <= LOAD;
            end else begin
              cmd_err <= 1'b1;
              state   <= IDLE;
            end
`else
            cmd_err <= 1'b1;
            state   <= IDLE;
`endif
          end else if ((rx_done_tick && rx_byte == PS2_ERROR) || expired) begin
            cmd_err <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// tb_ps2_cmd_sequencer: scoreboard bench for the PS/2 command sequencer
module tb_ps2_cmd_sequencer;
  import ps2_pkg::*;
  logic       clk = 1'b0, reset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_has_arg = 1'b0, tx_finished = 1'b0, rx_done_tick = 1'b0;
  logic [7:0] cmd_byte = '0, arg_byte = '0, rx_byte = '0;
  logic       cmd_ready, w_enable, scan_valid, cmd_done, cmd_err, busy;
  logic [7:0] data, scan_code;
  int         n_run = 0, n_fail = 0;
  logic [7:0] exp_tx[$], exp_scan[$];
  logic       exp_res[$];

  ps2_cmd_sequencer #(.ACK_TIMEOUT(1000), .MAX_RETRY(3)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_byte(cmd_byte), .cmd_has_arg(cmd_has_arg), .arg_byte(arg_byte),
    .w_enable(w_enable), .data(data), .tx_finished(tx_finished),
    .rx_done_tick(rx_done_tick), .rx_byte(rx_byte), .scan_valid(scan_valid),
    .scan_code(scan_code), .cmd_done(cmd_done), .cmd_err(cmd_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // scoreboard: every DUT output event pops and checks the expected queues
  always @(negedge clk) if (!reset) begin
    if (w_enable) begin
      if (exp_tx.size() != 0) check("tx_data", data, exp_tx.pop_front());
      else check("tx_unexpected", w_enable, 0);
    end
    if (scan_valid) begin
      if (exp_scan.size() != 0) check("scan_code", scan_code, exp_scan.pop_front());
      else check("scan_unexpected", scan_valid, 0);
    end
    if (cmd_done || cmd_err) begin
      check("done_err_excl", cmd_done & cmd_err, 0);
      if (exp_res.size() != 0) check("result_err", cmd_err, exp_res.pop_front());
      else check("result_unexpected", cmd_done | cmd_err, 0);
    end
  end

  task automatic send_cmd(input logic [7:0] c, input logic h, input logic [7:0] a);
    @(posedge clk); #1;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_byte = c; cmd_has_arg = h; arg_byte = a;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_wen();
    int k = 0;
    do begin @(negedge clk); k++; end while (!w_enable && k < 50);
    check("wen_seen", w_enable, 1);
  endtask

  task automatic pulse_tx();
    @(posedge clk); #1 tx_finished = 1'b1;
    @(posedge clk); #1 tx_finished = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    @(posedge clk); #1 rx_done_tick = 1'b1; rx_byte = b;
    @(posedge clk); #1 rx_done_tick = 1'b0;
  endtask

  task automatic queues_empty(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_tx_left"}, exp_tx.size(), 0);
    check({tag, "_scan_left"}, exp_scan.size(), 0);
    check({tag, "_res_left"}, exp_res.size(), 0);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_wen", w_enable, 0);
    check("rst_data", data, 0);
    check("rst_done_err", {cmd_done, cmd_err}, 0);
    reset = 1'b0;

    // single opcode, ACKed; rx byte in IDLE is forwarded
    exp_scan.push_back(8'h5A);
    pulse_rx(8'h5A);
    exp_tx.push_back(8'hF4); exp_res.push_back(1'b0);
    send_cmd(8'hF4, 1'b0, 8'h00);
    wait_wen();
    pulse_tx();
    pulse_rx(PS2_ACK);
    check("t1_done_lat", cmd_done, 1);
    check("t1_ready", cmd_ready, 1);
    queues_empty("t1");

    // opcode + argument; cmd_valid while busy is ignored
    exp_tx.push_back(PS2_SET_LEDS); exp_tx.push_back(8'h07); exp_res.push_back(1'b0);
    send_cmd(PS2_SET_LEDS, 1'b1, 8'h07);
    wait_wen();
    @(posedge clk); #1 cmd_valid = 1'b1; cmd_byte = 8'hAA;
    check("t2_busy_ready", cmd_ready, 0);
    @(posedge clk); #1 cmd_valid = 1'b0;
    pulse_tx();
    pulse_rx(PS2_ACK);
    check("t2_arg_lat", w_enable, 1);
    wait_wen();
    pulse_tx();
    pulse_rx(PS2_ACK);
    check("t2_done_lat", cmd_done, 1);
    queues_empty("t2");

    // resend on argument
`ifdef PS2_CMD_RETRY_EN
    exp_tx.push_back(PS2_SET_LEDS); exp_tx.push_back(8'h02); exp_tx.push_back(8'h02);
    exp_res.push_back(1'b0);
    send_cmd(PS2_SET_LEDS, 1'b1, 8'h02);
    wait_wen(); pulse_tx(); pulse_rx(PS2_ACK);
    wait_wen(); pulse_tx(); pulse_rx(PS2_RESEND);
    check("t3_resend_lat", w_enable, 1);
    wait_wen(); pulse_tx(); pulse_rx(PS2_ACK);
    check("t3_done_lat", cmd_done, 1);
    queues_empty("t3a");
    exp_tx.push_back(PS2_SET_LEDS);
    for (int i = 0; i < 4; i++) exp_tx.push_back(8'h02);
    exp_res.push_back(1'b1);
    send_cmd(PS2_SET_LEDS, 1'b1, 8'h02);
    wait_wen(); pulse_tx(); pulse_rx(PS2_ACK);
    for (int i = 0; i < 3; i++) begin
      wait_wen(); pulse_tx(); pulse_rx(PS2_RESEND);
    end
    wait_wen(); pulse_tx(); pulse_rx(PS2_RESEND);
    check("t3_exhaust_err", cmd_err, 1);
    queues_empty("t3b");
`else
    exp_tx.push_back(PS2_SET_LEDS); exp_tx.push_back(8'h02); exp_res.push_back(1'b1);
    send_cmd(PS2_SET_LEDS, 1'b1, 8'h02);
    wait_wen(); pulse_tx(); pulse_rx(PS2_ACK);
    wait_wen(); pulse_tx(); pulse_rx(PS2_RESEND);
    check("t3_err_lat", cmd_err, 1);
    check("t3_no_resend", w_enable, 0);
    queues_empty("t3");
`endif

    // device error byte
    exp_tx.push_back(8'hF2); exp_res.push_back(1'b1);
    send_cmd(8'hF2, 1'b0, 8'h00);
    wait_wen(); pulse_tx(); pulse_rx(PS2_ERROR);
    check("t3_fc_err", cmd_err, 1);
    queues_empty("t3fc");

    // scan byte in WAIT_ACK forwarded; rx+tx same cycle in WAIT_TX
    exp_tx.push_back(8'hF4); exp_scan.push_back(8'h29); exp_scan.push_back(8'h1C);
    exp_res.push_back(1'b0);
    send_cmd(8'hF4, 1'b0, 8'h00);
    wait_wen();
    @(posedge clk); #1 tx_finished = 1'b1; rx_done_tick = 1'b1; rx_byte = 8'h29;
    @(posedge clk); #1 tx_finished = 1'b0; rx_done_tick = 1'b0;
    pulse_rx(8'h1C);
    check("t4_not_done", cmd_done | cmd_err, 0);
    pulse_rx(PS2_ACK);
    check("t4_done_lat", cmd_done, 1);
    queues_empty("t4");

    // timeout, with a scan byte midway that must not restart the timer
    exp_tx.push_back(8'hF4); exp_scan.push_back(8'h33); exp_res.push_back(1'b1);
    send_cmd(8'hF4, 1'b0, 8'h00);
    wait_wen();
    pulse_tx();
    begin
      int n = 0;
      do begin
        @(posedge clk); #1;
        n++;
        rx_done_tick = (n == 500);
        rx_byte = 8'h33;
      end while (!cmd_err && n < 1100);
      rx_done_tick = 1'b0;
      check("t5_timeout_cycles", n, 1000);
    end
    queues_empty("t5");
    exp_tx.push_back(8'hF4); exp_res.push_back(1'b0);
    send_cmd(8'hF4, 1'b0, 8'h00);
    wait_wen(); pulse_tx(); pulse_rx(PS2_ACK);
    check("t5_next_done", cmd_done, 1);
    queues_empty("t5b");

    // reset while waiting for the transmitter
    exp_tx.push_back(8'hFF);
    send_cmd(8'hFF, 1'b0, 8'h00);
    wait_wen();
    @(posedge clk); #1 reset = 1'b1;
    check("t6_busy_before", busy, 1);
    @(posedge clk); #1 reset = 1'b0;
    check("t6_ready", cmd_ready, 1);
    check("t6_data", data, 0);
    pulse_tx();
    repeat (5) @(posedge clk);
    #1;
    check("t6_still_idle", cmd_ready, 1);
    check("t6_no_wen", w_enable, 0);
    queues_empty("t6");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
